seq_multiplier: RTL
===================

// Module: seq_multiplier
// PURPOSE
//   Iterative shift-add multiplier in the execute stage; its product drives the mul operand of
//   the ALU result selector.
//   - One bit of the multiplier operand per cycle; output is the low WIDTH bits of a*b.
//   - Control unit holds the pipeline while busy and consumes the one-cycle done pulse.
// PARAMETERS
//   WIDTH    32    operand and product width in bits (>= 2)
// PORTS
//   clk      in   1      single clock; all state updates on rising edge
//   rst_n    in   1      reset, asynchronous and active-low
//   start    in   1      request a new multiply; sampled only in IDLE or DONE
//   flush    in   1      abort the operation in flight (pipeline flush)
//   a        in   WIDTH  multiplicand, captured on an accepted start
//   b        in   WIDTH  multiplier, captured on an accepted start
//   busy     out  1      high in RUN state
//   done     out  1      one-cycle pulse; product valid this cycle
//   product  out  WIDTH  (a*b) mod 2^WIDTH, held until the next completion
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, busy=0, done=0, product=0, internal regs=0.
//   FSM states: IDLE, RUN, DONE.
//     IDLE: start=1 -> load mcand=a, mplier=b, acc=0, count=0; go to RUN.
//     RUN: each cycle:
//       - if mplier[0], acc += mcand (mod 2^WIDTH)
//       - mcand <<= 1; mplier >>= 1; count++
//       - exit to DONE at the end of the cycle in which count reaches WIDTH
//     DONE: done=1 for exactly this cycle; product <= final acc on entry.
//       - start=1 here -> reload operands and go to RUN (back-to-back, no IDLE bubble)
//       - otherwise go to IDLE
//   Latency: start sampled at edge N -> done high in cycle N+1+WIDTH (33 cycles at default).
//   Throughput: one result per WIDTH+1 cycles back-to-back.
//   busy = (state==RUN), registered.
//   start while RUN: ignored; operands not re-captured.
//   flush:
//     - any state -> IDLE next edge; done forced 0; product unchanged
//     - flush wins over simultaneous start, including start in DONE
//   product register written only on DONE entry; holds across IDLE and flushes.
//   Arithmetic: all adds/shifts truncate to WIDTH bits; overflow silently discarded.
//     - Unsigned and two's-complement low halves are identical; no sign handling.
//   a/b may change freely after the accepting edge.
// CONFIGURATION
//   MUL_EARLY_TERM_EN
//     - Defined: RUN also exits to DONE when the updated mplier is zero.
//       - k = max(1, index of highest set bit of b + 1) RUN cycles; done in cycle N+1+k.
//       - b=0 or b=1 -> done at N+2.
//     - Undefined: fixed WIDTH RUN cycles; latency data-independent.
//     - Product value identical in both builds.
// TESTING
//   1. rst_n=0 mid-RUN (cycle 10) -> busy=0, done=0, product=0 immediately; state IDLE after release.
//   2. a=7, b=6, start 1 cycle -> busy 32 cycles, done pulse at cycle 33, product=42, held after.
//   3. a=0xFFFF_FFFF, b=0xFFFF_FFFF -> product=0x0000_0001 (truncation); a=0x8000_0000, b=2 -> product=0.
//   4. Back-to-back: start held in DONE with a=3, b=5 -> no IDLE cycle; next done 33 cycles later, product=15.
//      start pulsed during RUN -> ignored.
//   5. flush at RUN cycle 5 with prior product=42 -> IDLE next edge; no done; product stays 42.
//      flush+start together in DONE -> IDLE.
//   6. MUL_EARLY_TERM_EN: b=0 -> done at cycle 2, product=0; b=1, a=9 -> cycle 2, product=9;
//      b=0x0000_0100, a=3 -> cycle 10, product=0x300.
//      Without the macro, same vectors -> cycle 33, same products.

Source files
------------

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-add multiplier, one multiplier bit per cycle, low WIDTH bits of a*b.
// Define MUL_EARLY_TERM_EN to leave RUN as soon as the remaining multiplier bits are all zero.
module seq_multiplier #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             flush,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
   state_t r_state, w_state_nxt;
   logic [WIDTH-1:0] r_mcand, r_mplier, r_acc, w_acc_sum, w_mplier_shr;
   logic [CW-1:0] r_count;
   logic w_load, w_last;
   assign w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_mplier_shr = r_mplier >> 1;
`ifdef MUL_EARLY_TERM_EN
   assign w_last = (r_count == CW'(WIDTH - 1)) || (w_mplier_shr == '0);
`else
   assign w_last = (r_count == CW'(WIDTH - 1));
`endif
   always_comb begin
      w_load      = !flush && start && (r_state != S_RUN);
      w_state_nxt = flush ? S_IDLE :
                    w_load ? S_RUN :
                    (r_state == S_RUN) ? (w_last ? S_DONE : S_RUN) : S_IDLE;
   end
   // busy/done are registered from the next state so they line up with it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         busy    <= (w_state_nxt == S_RUN);
         done    <= (w_state_nxt == S_DONE);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_count  <= '0;
         product  <= '0;
      end else begin
         if (w_load) begin
            r_mcand  <= a;
            r_mplier <= b;
            r_acc    <= '0;
            r_count  <= '0;
         end else if (r_state == S_RUN && !flush) begin
            r_acc    <= w_acc_sum;
            r_mcand  <= r_mcand << 1;
            r_mplier <= w_mplier_shr;
            r_count  <= r_count + 1'b1;
         end
         if (w_state_nxt == S_DONE) product <= w_acc_sum;
      end
   end
endmodule
